fpga_operand_entry: RTL and testbench
=====================================

# fpga_operand_entry

Board-side input controller for the FPGA ALU bring-up flow. It samples the active-low push buttons and slide switches, then synchronizes and debounces them, and turns button presses into single-cycle events. A small state machine sequences operand A, operand B and the ALU opcode into holding registers that drive the ALU ports directly. It is the input counterpart of the seven-segment result display: switches and keys come in here, and the ALU result goes out through the display path.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a level change. 10 ms at 50 MHz; benches use 4.
- DATA_W, default 32: operand width.

Ports:
- CLK, in, 1: system clock.
- nRST, in, 1: asynchronous, active-low reset.
- key_n, in, 4: raw push buttons, active-low, asynchronous to CLK. key_n[0] = ENTER, key_n[1] = CANCEL, key_n[3:2] = spare.
- sw, in, 18: raw slide switches, asynchronous. sw[16] is the sign bit and sw[15:0] is the data.
- port_a, out, DATA_W: operand A holding register.
- port_b, out, DATA_W: operand B holding register.
- aluop, out, 4: opcode holding register, type aluop_t.
- op_valid, out, 1: high while port_a, port_b and aluop form a complete, committed operation.
- entry_state, out, 2: current state, for the LEDs.
- keys_db, out, 4: debounced key levels, active-high (1 = pressed).

## Operation
- **Synchronizers:** key_n and sw each pass through a 2-flop synchronizer. Reset value is 1 for the keys and 0 for the switches.
- **Debounce, per key:**
  - Each key keeps a stable level (reset 1, released) and a counter (reset 0).
  - The counter clears whenever the synced level equals the stable level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the stable level takes the synced level and the counter clears.
- **Press event:** a one-cycle pulse when the stable level goes 1→0. Release produces no event.
- **Held through reset:** a key held through reset release produces exactly one press after debounce.
- **Switch sample:** the synced switches feed a sign-extended value, sext = {(DATA_W-16){sw[16]}, sw[15:0]}. Switches are not debounced; they are sampled only on an ENTER event.
- **State machine** (entry_state_t):
  - LOAD_A (0), on ENTER: port_a ← sext, go to LOAD_B.
  - LOAD_B (1), on ENTER: port_b ← sext, go to LOAD_OP.
  - LOAD_OP (2), on ENTER: aluop ← synced sw[3:0], op_valid ← 1, go to SHOW.
  - SHOW (3), on ENTER: op_valid ← 0, go to LOAD_A. The holding registers are retained.
- **CANCEL event, any state:** op_valid ← 0 and go to LOAD_A. The holding registers are retained.
- **ENTER and CANCEL in the same cycle:** CANCEL wins and ENTER is ignored.
- **Spare keys:** debounced and reported on keys_db only; they have no state effect.
- **Out-of-range state:** state 3 is SHOW. Any illegal encoding cannot occur with a 2-bit type, and the default branch goes to LOAD_A.

## Timing
- Reset values:
  - port_a = 0, port_b = 0, aluop = 0
  - op_valid = 0, entry_state = LOAD_A, keys_db = 0
- **Key latency:** a raw key level change held steady reaches the stable level DEBOUNCE_CYCLES+2 clock edges later. The press pulse is combinational from that stable-level transition.
- **Register latency:** the holding registers and the state update on the edge after the pulse. Total latency from the raw press is DEBOUNCE_CYCLES+3 edges.
- **Glitches:** a bounce shorter than DEBOUNCE_CYCLES synced cycles produces no event. Each opposite sample restarts the count.
- **Switch capture:** the switch value captured is the one synchronized at the capture edge. Switch changes within the final 2 cycles before the ENTER event are not guaranteed to be seen.
- **Outputs:** all outputs are registered. The holding registers are stable except on their own capture edge.
- **Reset assertion mid-sequence:** all outputs immediately return to their reset values; no edge is needed.

## Structure
- **cpu_types_pkg** gains:
  - the entry_state_t enum: LOAD_A, LOAD_B, LOAD_OP, SHOW.
  - the DEBOUNCE_50MHZ constant (500000).
  - aluop_t already lives there and is reused.
- **key_debounce** is the sub-module, instantiated 4×. It contains the synchronizer, counter, stable level and press-pulse output. It takes parameter DEBOUNCE_CYCLES.
- **Top-level logic:** the top contains the switch synchronizer, the sign extension and the FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset:** drive nRST low mid-sequence → all outputs go to their reset values asynchronously. After release, entry_state = 0 and op_valid = 0.
- **Full entry:**
  - Stimulus: sw = 0x1FFFF, ENTER; then sw = 0x00005, ENTER; then sw[3:0] = 0x3, ENTER.
  - Response: port_a = 0xFFFFFFFF, port_b = 0x00000005, aluop = 3, op_valid = 1, entry_state = 3.
  - Each update lands exactly 7 edges after its raw press.
- **Bounce:** toggle key_n[0] with low pulses of 1–3 cycles separated by highs → no state change. A following 6-cycle low → exactly one advance.
- **Cancel:**
  - Stimulus: from LOAD_OP with port_a = 0x12, press CANCEL.
  - Response: entry_state = 0, op_valid = 0, port_a still 0x12.
  - Simultaneous ENTER+CANCEL from LOAD_B → LOAD_A, port_b unchanged.
- **Wrap:** from SHOW, press ENTER → op_valid = 0, entry_state = 0, registers retained. The next ENTER with sw = 0x00010 → port_a = 0x10.
- **Held key:**
  - Stimulus: key_n[0] held low across the nRST release.
  - Response: exactly one advance to LOAD_B after 7 edges, none while the key stays held. After release and re-press, one more advance.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU bring-up types: ALU opcodes, operand-entry states and board timing constants.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_NOR   = 4'h5,
    ALU_SLL   = 4'h6,
    ALU_SRL   = 4'h7,
    ALU_SRA   = 4'h8,
    ALU_SLT   = 4'h9,
    ALU_SLTU  = 4'hA,
    ALU_LUI   = 4'hB,
    ALU_PASSA = 4'hC,
    ALU_PASSB = 4'hD,
    ALU_MUL   = 4'hE,
    ALU_RSV   = 4'hF
  } aluop_t;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } entry_state_t;

  // 10 ms of stable level at 50 MHz
  localparam int DEBOUNCE_50MHZ = 500000;

endpackage

// File: rtl/key_debounce.sv
// One active-low push button: 2-flop synchronizer, stable-level debounce and a
// single-cycle press pulse on the released->pressed transition of the stable level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n_raw,
  output logic pressed,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  assign synced = sync_q[1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q   <= 2'b11;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
    end else begin
      sync_q   <= {sync_q[0], key_n_raw};
      stable_d <= stable;
      // any sample matching the accepted level restarts the qualification window
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pressed     = ~stable;
  assign press_pulse = stable_d & ~stable;

endmodule

// File: rtl/fpga_operand_entry.sv
// Board input controller: debounced ENTER/CANCEL keys step a 4-state FSM that
// loads operand A, operand B and the opcode from the slide switches.
module fpga_operand_entry
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
  parameter int DATA_W          = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [3:0]         key_n,
  input  logic [17:0]        sw,
  output logic [DATA_W-1:0]  port_a,
  output logic [DATA_W-1:0]  port_b,
  output aluop_t             aluop,
  output logic               op_valid,
  output entry_state_t       entry_state,
  output logic [3:0]         keys_db
);

  logic [3:0]        press;
  logic [16:0]       sw_s1, sw_s2;
  logic [DATA_W-1:0] sext;
  logic              enter_ev, cancel_ev;

  entry_state_t      state_n;
  logic [DATA_W-1:0] port_a_n, port_b_n;
  aluop_t            aluop_n;
  logic              op_valid_n;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .CLK        (CLK),
      .nRST       (nRST),
      .key_n_raw  (key_n[i]),
      .pressed    (keys_db[i]),
      .press_pulse(press[i])
    );
  end

  // spare keys only report their level; sw[17] has no function
  logic unused_bits;
  assign unused_bits = ^{press[3:2], sw[17]};

  assign enter_ev  = press[0];
  assign cancel_ev = press[1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw[16:0];
      sw_s2 <= sw_s1;
    end
  end

  assign sext = {{(DATA_W-16){sw_s2[16]}}, sw_s2[15:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      entry_state <= LOAD_A;
      port_a      <= '0;
      port_b      <= '0;
      aluop       <= ALU_ADD;
      op_valid    <= 1'b0;
    end else begin
      entry_state <= state_n;
      port_a      <= port_a_n;
      port_b      <= port_b_n;
      aluop       <= aluop_n;
      op_valid    <= op_valid_n;
    end
  end

  // CANCEL takes priority over a coincident ENTER; holding registers are never cleared here
  always_comb begin
    state_n    = entry_state;
    port_a_n   = port_a;
    port_b_n   = port_b;
    aluop_n    = aluop;
    op_valid_n = op_valid;
    if (cancel_ev) begin
      state_n    = LOAD_A;
      op_valid_n = 1'b0;
    end else if (enter_ev) begin
      case (entry_state)
        LOAD_A: begin
          port_a_n = sext;
          state_n  = LOAD_B;
        end
        LOAD_B: begin
          port_b_n = sext;
          state_n  = LOAD_OP;
        end
        LOAD_OP: begin
          aluop_n    = aluop_t'(sw_s2[3:0]);
          op_valid_n = 1'b1;
          state_n    = SHOW;
        end
        SHOW: begin
          op_valid_n = 1'b0;
          state_n    = LOAD_A;
        end
        default: state_n = LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_operand_entry.sv
// Directed bench for fpga_operand_entry with DEBOUNCE_CYCLES = 4: a table of key
// presses with expected register contents, plus latency, bounce, reset and held-key sequences.
module tb_fpga_operand_entry;

  logic        CLOCK_50;
  logic        nRST;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic [31:0] port_a, port_b;
  logic [3:0]  aluop;
  logic        op_valid;
  logic [1:0]  entry_state;
  logic [3:0]  keys_db;

  int checks   = 0;
  int failures = 0;

  fpga_operand_entry #(.DEBOUNCE_CYCLES(4), .DATA_W(32)) dut (
    .CLK        (CLOCK_50),
    .nRST       (nRST),
    .key_n      (key_n),
    .sw         (sw),
    .port_a     (port_a),
    .port_b     (port_b),
    .aluop      (aluop),
    .op_valid   (op_valid),
    .entry_state(entry_state),
    .keys_db    (keys_db)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0]  keys;
    logic [17:0] swv;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        v;
  } vec_t;

  vec_t vecs[13];

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // hold the given keys pressed long enough to debounce, then release and settle
  task automatic press(input logic [3:0] keys, input logic [17:0] swv);
    sw    = swv;
    key_n = ~keys;
    step(8);
    key_n = 4'hF;
    step(8);
  endtask

  initial begin
    //          keys   sw        state a             b             op    v
    vecs[0]  = '{4'h1, 18'h1FFFF, 2'd1, 32'hFFFFFFFF, 32'h00000000, 4'h0, 1'b0};
    vecs[1]  = '{4'h1, 18'h00005, 2'd2, 32'hFFFFFFFF, 32'h00000005, 4'h0, 1'b0};
    vecs[2]  = '{4'h1, 18'h00003, 2'd3, 32'hFFFFFFFF, 32'h00000005, 4'h3, 1'b1};
    vecs[3]  = '{4'h1, 18'h00010, 2'd0, 32'hFFFFFFFF, 32'h00000005, 4'h3, 1'b0};
    vecs[4]  = '{4'h1, 18'h00010, 2'd1, 32'h00000010, 32'h00000005, 4'h3, 1'b0};
    vecs[5]  = '{4'h1, 18'h0ABCD, 2'd2, 32'h00000010, 32'h0000ABCD, 4'h3, 1'b0};
    vecs[6]  = '{4'h2, 18'h00007, 2'd0, 32'h00000010, 32'h0000ABCD, 4'h3, 1'b0};
    vecs[7]  = '{4'h1, 18'h00012, 2'd1, 32'h00000012, 32'h0000ABCD, 4'h3, 1'b0};
    vecs[8]  = '{4'h1, 18'h18000, 2'd2, 32'h00000012, 32'hFFFF8000, 4'h3, 1'b0};
    vecs[9]  = '{4'h2, 18'h00000, 2'd0, 32'h00000012, 32'hFFFF8000, 4'h3, 1'b0};
    vecs[10] = '{4'h1, 18'h00001, 2'd1, 32'h00000001, 32'hFFFF8000, 4'h3, 1'b0};
    vecs[11] = '{4'h3, 18'h00007, 2'd0, 32'h00000001, 32'hFFFF8000, 4'h3, 1'b0};
    vecs[12] = '{4'h4, 18'h00009, 2'd0, 32'h00000001, 32'hFFFF8000, 4'h3, 1'b0};

    nRST  = 1'b0;
    key_n = 4'hF;
    sw    = '0;
    step(3);
    check("rst_port_a", port_a, 32'h0);
    check("rst_port_b", port_b, 32'h0);
    check("rst_aluop", {28'h0, aluop}, 32'h0);
    check("rst_op_valid", {31'h0, op_valid}, 32'h0);
    check("rst_state", {30'h0, entry_state}, 32'h0);
    check("rst_keys_db", {28'h0, keys_db}, 32'h0);
    nRST = 1'b1;
    step(2);

    for (int i = 0; i < 13; i++) begin
      press(vecs[i].keys, vecs[i].swv);
      check($sformatf("v%0d_state", i), {30'h0, entry_state}, {30'h0, vecs[i].st});
      check($sformatf("v%0d_port_a", i), port_a, vecs[i].a);
      check($sformatf("v%0d_port_b", i), port_b, vecs[i].b);
      check($sformatf("v%0d_aluop", i), {28'h0, aluop}, {28'h0, vecs[i].op});
      check($sformatf("v%0d_op_valid", i), {31'h0, op_valid}, {31'h0, vecs[i].v});
    end

    // exact latency: stable level at edge 6, registers at edge 7
    sw    = 18'h00022;
    key_n = 4'hE;
    step(5);
    check("lat_keys_db_e5", {28'h0, keys_db}, 32'h0);
    step(1);
    check("lat_keys_db_e6", {28'h0, keys_db}, 32'h1);
    check("lat_state_e6", {30'h0, entry_state}, 32'd0);
    check("lat_port_a_e6", port_a, 32'h00000001);
    step(1);
    check("lat_state_e7", {30'h0, entry_state}, 32'd1);
    check("lat_port_a_e7", port_a, 32'h00000022);
    key_n = 4'hF;
    step(8);

    // bounce: short lows never qualify
    for (int w = 1; w <= 3; w++) begin
      key_n = 4'hE;
      step(w);
      key_n = 4'hF;
      step(3);
    end
    step(8);
    check("bounce_state", {30'h0, entry_state}, 32'd1);
    check("bounce_keys_db", {28'h0, keys_db}, 32'h0);
    sw    = 18'h00009;
    key_n = 4'hE;
    step(6);
    key_n = 4'hF;
    step(10);
    check("bounce_adv_state", {30'h0, entry_state}, 32'd2);
    check("bounce_adv_port_b", port_b, 32'h00000009);

    // asynchronous reset mid-sequence with a key held
    key_n = 4'hE;
    step(8);
    check("pre_rst_state", {30'h0, entry_state}, 32'd3);
    check("pre_rst_op_valid", {31'h0, op_valid}, 32'h1);
    check("pre_rst_aluop", {28'h0, aluop}, 32'h9);
    check("pre_rst_keys_db", {28'h0, keys_db}, 32'h1);
    nRST = 1'b0;
    #2;
    check("async_port_a", port_a, 32'h0);
    check("async_port_b", port_b, 32'h0);
    check("async_aluop", {28'h0, aluop}, 32'h0);
    check("async_op_valid", {31'h0, op_valid}, 32'h0);
    check("async_state", {30'h0, entry_state}, 32'd0);
    check("async_keys_db", {28'h0, keys_db}, 32'h0);
    @(posedge CLOCK_50);
    #1;
    nRST = 1'b1;

    // key held across reset release: one press after 7 edges, none while still held
    step(6);
    check("held_state_e6", {30'h0, entry_state}, 32'd0);
    step(1);
    check("held_state_e7", {30'h0, entry_state}, 32'd1);
    check("held_port_a_e7", port_a, 32'h00000009);
    step(20);
    check("held_state_long", {30'h0, entry_state}, 32'd1);
    key_n = 4'hF;
    step(8);
    press(4'h1, 18'h00005);
    check("repress_state", {30'h0, entry_state}, 32'd2);
    check("repress_port_b", port_b, 32'h00000005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
